// File: rtl/axil_regfile_pkg.sv
// ============================================================================
//  Module      : axil_regfile_pkg
//  Description : Shared AXI-Lite response codes, CSR layout constants and a
//                small index-width helper for the multi-channel stream
//                capture register file.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axil_regfile_pkg;

   typedef logic [1:0] resp_t;

   localparam resp_t c_resp_okay   = 2'b00;
   localparam resp_t c_resp_slverr = 2'b10;

   // Each channel owns two consecutive CSR words: beat count, then frame count
   localparam int c_csr_stride    = 2;
   localparam int c_csr_beat_ofs  = 0;
   localparam int c_csr_frame_ofs = 1;

   // Index width that stays legal (>= 1 bit) even for a single channel
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/axil_regfile_axis_mc_wr_if.sv
// ============================================================================
//  Module      : axil_regfile_axis_mc_wr_if
//  Description : AXI-Lite bus bundle with master and slave views.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axil_regfile_axis_mc_wr_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
);
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [2:0]            awprot;
   logic                  awvalid;
   logic                  awready;
   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  wvalid;
   logic                  wready;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [2:0]            arprot;
   logic                  arvalid;
   logic                  arready;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

`default_nettype wire

// File: rtl/axis_rr_arbiter.sv
// ============================================================================
//  Module      : axis_rr_arbiter
//  Description : Round-robin arbiter, one-hot grant. After a grant to channel
//                c the search starts at c+1; idle requesters are skipped.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_rr_arbiter
   import axil_regfile_pkg::*;
#(
   parameter int CH_NUM = 4,
   localparam int IDX_W = idx_width(CH_NUM)
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic [CH_NUM-1:0] i_req,
   output logic      [CH_NUM-1:0] o_grant,
   output logic      [IDX_W-1:0]  o_grant_idx,
   output logic                   o_grant_vld
);

   logic [IDX_W-1:0] r_prio;

   // Pick the first requester at or after the current priority position
   always_comb begin : p_pick
      logic [IDX_W-1:0] w_idx;
      o_grant     = '0;
      o_grant_idx = '0;
      o_grant_vld = 1'b0;
      w_idx       = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         w_idx = IDX_W'((int'(r_prio) + i) % CH_NUM);
         if (!o_grant_vld && i_req[w_idx]) begin
            o_grant[w_idx] = 1'b1;
            o_grant_idx    = w_idx;
            o_grant_vld    = 1'b1;
         end
      end
   end

   // Every grant is an accepted beat, so priority moves past the winner
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prio <= '0;
      end else if (o_grant_vld) begin
         r_prio <= IDX_W'((int'(o_grant_idx) + 1) % CH_NUM);
      end
   end

endmodule

`default_nettype wire

// File: rtl/axil_regfile_axis_mc_wr.sv
// ============================================================================
//  Module      : axil_regfile_axis_mc_wr
//  Description : Multi-channel AXI-Stream capture into per-channel banks,
//                read back over AXI-Lite, with per-channel beat/frame CSRs.
//                Build option AXIL_REGFILE_MC_WRAP_EN: banks wrap and never
//                fill; otherwise a bank stops accepting after DEPTH beats
//                until its CSRs are written.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axil_regfile_axis_mc_wr
   import axil_regfile_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int CH_NUM     = 4,
   parameter int DEPTH      = 256
) (
   input  wire logic                         axil_clk,
   input  wire logic                         axil_rst,
   input  wire logic [CH_NUM*DATA_WIDTH-1:0] s_axis_tdata,
   input  wire logic [CH_NUM-1:0]            s_axis_tvalid,
   input  wire logic [CH_NUM-1:0]            s_axis_tlast,
   output logic      [CH_NUM-1:0]            s_axis_tready,
   output logic      [CH_NUM*32-1:0]         axis_write_num,
   axil_regfile_axis_mc_wr_if.slave          s_axil
);

   localparam int c_word_lsb  = $clog2(STRB_WIDTH);
   localparam int c_idx_w     = idx_width(CH_NUM);
   localparam int c_ptr_w     = $clog2(DEPTH);
   localparam int c_b         = $clog2(CH_NUM * DEPTH);
   localparam int c_csr_words = c_csr_stride * CH_NUM;

   logic [DATA_WIDTH-1:0] r_mem [CH_NUM*DEPTH];
   logic [c_ptr_w-1:0]    r_ptr   [CH_NUM];
   logic [31:0]           r_beat  [CH_NUM];
   logic [31:0]           r_frame [CH_NUM];

   logic [CH_NUM-1:0]     w_req, w_grant, w_full, w_clr;
   logic [c_idx_w-1:0]    w_gnt_idx;
   logic                  w_gnt_vld;
   logic [c_b-1:0]        w_wr_addr;
   logic [DATA_WIDTH-1:0] w_wr_data;

   logic [c_b:0]          w_aw_word, w_ar_word;
   logic                  w_aw_ok, w_ar_ok, w_wr_accept, w_rd_accept;
   logic [c_idx_w-1:0]    w_aw_ch, w_rd_ch;

   logic                  r_bvalid, r_rvalid;
   resp_t                 r_bresp, r_rresp;
   logic [DATA_WIDTH-1:0] r_rdata;

   logic                  w_unused_bits;
   assign w_unused_bits = ^{s_axil.awaddr, s_axil.araddr, s_axil.awprot,
                            s_axil.arprot, s_axil.wdata, s_axil.wstrb};

   // Address decode: word bit c_b selects CSR space, lower bits index within it
   assign w_aw_word = s_axil.awaddr[c_word_lsb +: c_b+1];
   assign w_ar_word = s_axil.araddr[c_word_lsb +: c_b+1];
   assign w_aw_ok   = w_aw_word[c_b] && (w_aw_word[c_b-1:0] < c_b'(c_csr_words));
   assign w_ar_ok   = w_ar_word[c_b] && (w_ar_word[c_b-1:0] < c_b'(c_csr_words));
   assign w_aw_ch   = c_idx_w'(w_aw_word[c_b-1:0] >> 1);
   assign w_rd_ch   = c_idx_w'(w_ar_word[c_b-1:0] >> 1);

   assign w_wr_accept   = ~axil_rst & s_axil.awvalid & s_axil.wvalid & ~r_bvalid;
   assign w_rd_accept   = ~axil_rst & s_axil.arvalid & ~r_rvalid;
   assign s_axil.awready = w_wr_accept;
   assign s_axil.wready  = w_wr_accept;
   assign s_axil.arready = ~axil_rst & ~r_rvalid;
   assign s_axil.bvalid  = r_bvalid;
   assign s_axil.bresp   = r_bresp;
   assign s_axil.rvalid  = r_rvalid;
   assign s_axil.rresp   = r_rresp;
   assign s_axil.rdata   = r_rdata;

   axis_rr_arbiter #(.CH_NUM(CH_NUM)) u_arb (
      .clk         (axil_clk),
      .rst         (axil_rst),
      .i_req       (w_req),
      .o_grant     (w_grant),
      .o_grant_idx (w_gnt_idx),
      .o_grant_vld (w_gnt_vld)
   );

   assign w_wr_addr = c_b'(int'(w_gnt_idx) * DEPTH + int'(r_ptr[w_gnt_idx]));
   assign w_wr_data = s_axis_tdata[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];

   // Bank write port: one granted beat per cycle, contents not reset
   always_ff @(posedge axil_clk) begin
      if (w_gnt_vld) begin
         r_mem[w_wr_addr] <= w_wr_data;
      end
   end

   for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
`ifdef AXIL_REGFILE_MC_WRAP_EN
      assign w_full[c] = 1'b0;
`else
      assign w_full[c] = (r_beat[c] == 32'(DEPTH));
`endif
      // A pending CSR write on this channel removes it from arbitration
      assign w_clr[c] = w_wr_accept & w_aw_ok & (w_aw_ch == c_idx_w'(c));
      assign w_req[c] = ~axil_rst & s_axis_tvalid[c] & ~w_full[c] & ~w_clr[c];
      assign s_axis_tready[c] = w_grant[c];
      assign axis_write_num[c*32 +: 32] = r_beat[c];

      // Pointer and saturating counters; a clear overrides any beat
      always_ff @(posedge axil_clk or posedge axil_rst) begin
         if (axil_rst) begin
            r_ptr[c]   <= '0;
            r_beat[c]  <= '0;
            r_frame[c] <= '0;
         end else if (w_clr[c]) begin
            r_ptr[c]   <= '0;
            r_beat[c]  <= '0;
            r_frame[c] <= '0;
         end else if (w_grant[c]) begin
            r_ptr[c] <= r_ptr[c] + 1'b1;
            if (r_beat[c] != '1) r_beat[c] <= r_beat[c] + 32'd1;
            if (s_axis_tlast[c] && (r_frame[c] != '1)) r_frame[c] <= r_frame[c] + 32'd1;
         end
      end
   end

   // Write response: only in-range CSR words are writable
   always_ff @(posedge axil_clk or posedge axil_rst) begin
      if (axil_rst) begin
         r_bvalid <= 1'b0;
         r_bresp  <= c_resp_okay;
      end else if (w_wr_accept) begin
         r_bvalid <= 1'b1;
         r_bresp  <= w_aw_ok ? c_resp_okay : c_resp_slverr;
      end else if (s_axil.bready) begin
         r_bvalid <= 1'b0;
      end
   end

   // Read response: bank data, CSR counts, or zero with SLVERR past the CSRs
   always_ff @(posedge axil_clk or posedge axil_rst) begin
      if (axil_rst) begin
         r_rvalid <= 1'b0;
         r_rresp  <= c_resp_okay;
         r_rdata  <= '0;
      end else if (w_rd_accept) begin
         r_rvalid <= 1'b1;
         if (!w_ar_word[c_b]) begin
            r_rdata <= r_mem[w_ar_word[c_b-1:0]];
            r_rresp <= c_resp_okay;
         end else if (w_ar_ok) begin
            r_rdata <= DATA_WIDTH'((w_ar_word[0] == 1'(c_csr_frame_ofs)) ?
                                   r_frame[w_rd_ch] : r_beat[w_rd_ch]);
            r_rresp <= c_resp_okay;
         end else begin
            r_rdata <= '0;
            r_rresp <= c_resp_slverr;
         end
      end else if (s_axil.rready) begin
         r_rvalid <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_axil_regfile_axis_mc_wr.sv
// ============================================================================
//  Module      : tb_axil_regfile_axis_mc_wr
//  Description : Directed self-checking bench for axil_regfile_axis_mc_wr
//                (CH_NUM=4, DEPTH=256, 64-bit data). Honours
//                AXIL_REGFILE_MC_WRAP_EN for the fill scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axil_regfile_axis_mc_wr;

   localparam int CH = 4;
   localparam logic [31:0] CSR_BASE = 32'h0000_2000;  // word 1024 * 8 bytes

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [255:0] tdata = '0;
   logic [3:0]   tvalid = '0;
   logic [3:0]   tlast = '0;
   logic [3:0]   tready;
   logic [127:0] write_num;

   int n_vec = 0;
   int n_err = 0;

   axil_regfile_axis_mc_wr_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .STRB_WIDTH(8)) bus ();

   axil_regfile_axis_mc_wr #(
      .DATA_WIDTH(64), .ADDR_WIDTH(32), .STRB_WIDTH(8), .CH_NUM(CH), .DEPTH(256)
   ) dut (
      .axil_clk       (clk),
      .axil_rst       (rst),
      .s_axis_tdata   (tdata),
      .s_axis_tvalid  (tvalid),
      .s_axis_tlast   (tlast),
      .s_axis_tready  (tready),
      .axis_write_num (write_num),
      .s_axil         (bus)
   );

   always #5 clk = ~clk;

   task automatic bus_idle();
      bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 0;
      bus.wdata = '0;  bus.wstrb = '0;  bus.wvalid = 0; bus.bready = 1;
      bus.araddr = '0; bus.arprot = '0; bus.arvalid = 0; bus.rready = 1;
   endtask

   task automatic do_reset();
      tvalid = '0; tlast = '0;
      bus_idle();
      rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
   endtask

   task automatic send_beat(input int ch, input logic [63:0] d, input logic last,
                            output int waited);
      bit got = 0;
      waited = 0;
      tdata[ch*64 +: 64] = d; tlast[ch] = last; tvalid[ch] = 1;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk); got = tready[ch];
         @(posedge clk); #1;
         if (!got) waited++;
      end
      tvalid[ch] = 0; tlast[ch] = 0;
      n_vec++;
      if (!got) begin
         n_err++;
         $display("FAIL beat_timeout ch%0d: tready never seen, required accept within 20 cycles", ch);
      end
   endtask

   task automatic axil_write(input logic [31:0] addr, input logic [63:0] d,
                             output logic [1:0] resp);
      bit got = 0;
      resp = 2'b11;
      bus.awaddr = addr; bus.awvalid = 1; bus.wdata = d; bus.wstrb = 8'hFF;
      bus.wvalid = 1; bus.bready = 1;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk); got = bus.awready & bus.wready;
         @(posedge clk); #1;
      end
      bus.awvalid = 0; bus.wvalid = 0;
      n_vec++;
      if (!got) begin
         n_err++;
         $display("FAIL aw_timeout addr=%h: awready never seen, required within 20 cycles", addr);
      end
      got = 0;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk);
         if (bus.bvalid) begin got = 1; resp = bus.bresp; end
         @(posedge clk); #1;
      end
      n_vec++;
      if (!got) begin
         n_err++;
         $display("FAIL b_timeout addr=%h: bvalid never seen, required within 20 cycles", addr);
      end
   endtask

   task automatic axil_read(input logic [31:0] addr, output logic [63:0] d,
                            output logic [1:0] resp);
      bit got = 0;
      d = '0; resp = 2'b11;
      bus.araddr = addr; bus.arvalid = 1; bus.rready = 1;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk); got = bus.arready;
         @(posedge clk); #1;
      end
      bus.arvalid = 0;
      n_vec++;
      if (!got) begin
         n_err++;
         $display("FAIL ar_timeout addr=%h: arready never seen, required within 20 cycles", addr);
      end
      got = 0;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk);
         if (bus.rvalid) begin got = 1; d = bus.rdata; resp = bus.rresp; end
         @(posedge clk); #1;
      end
      n_vec++;
      if (!got) begin
         n_err++;
         $display("FAIL r_timeout addr=%h: rvalid never seen, required within 20 cycles", addr);
      end
   endtask

   task automatic test_reset();
      bus_idle();
      rst = 1;
      tvalid = 4'hF;
      bus.awvalid = 1; bus.wvalid = 1; bus.arvalid = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (tready !== 4'h0) begin n_err++; $display("FAIL rst_tready: got %h want 0", tready); end
      n_vec++;
      if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin
         n_err++; $display("FAIL rst_ready: got aw/w/ar %b want 000", {bus.awready, bus.wready, bus.arready});
      end
      n_vec++;
      if ({bus.bvalid, bus.rvalid} !== 2'b00) begin
         n_err++; $display("FAIL rst_valid: got b/r %b want 00", {bus.bvalid, bus.rvalid});
      end
      @(posedge clk); #1;
      tvalid = '0; bus_idle(); rst = 0;
      @(negedge clk);
      n_vec++;
      if (write_num !== '0) begin n_err++; $display("FAIL rst_write_num: got %h want 0", write_num); end
      n_vec++;
      if (bus.arready !== 1'b1) begin n_err++; $display("FAIL post_rst_arready: got %b want 1", bus.arready); end
      @(posedge clk); #1;
   endtask

   task automatic test_ch1_frame();
      logic [63:0] d; logic [1:0] r; int w;
      do_reset();
      for (int i = 0; i < 4; i++) send_beat(1, 64'hA0 + 64'(i), (i == 3), w);
      for (int i = 0; i < 4; i++) begin
         axil_read(32'((256 + i) * 8), d, r);
         n_vec++;
         if (d !== 64'hA0 + 64'(i) || r !== 2'b00) begin
            n_err++; $display("FAIL ch1_data[%0d]: got %h/%b want %h/00", i, d, r, 64'hA0 + 64'(i));
         end
      end
      axil_read(CSR_BASE + 32'd16, d, r);
      n_vec++;
      if (d !== 64'd4 || r !== 2'b00) begin n_err++; $display("FAIL ch1_beats: got %0d/%b want 4/00", d, r); end
      axil_read(CSR_BASE + 32'd24, d, r);
      n_vec++;
      if (d !== 64'd1 || r !== 2'b00) begin n_err++; $display("FAIL ch1_frames: got %0d/%b want 1/00", d, r); end
      n_vec++;
      if (write_num[63:32] !== 32'd4) begin n_err++; $display("FAIL ch1_write_num: got %0d want 4", write_num[63:32]); end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_g;
      do_reset();
      tvalid = 4'hF;
      for (int k = 0; k < 8; k++) begin
         exp_g = 4'b0001 << (k % 4);
         @(negedge clk);
         n_vec++;
         if (tready !== exp_g) begin n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", k, tready, exp_g); end
         @(posedge clk); #1;
      end
      tvalid = '0;
      @(negedge clk);
      n_vec++;
      if (write_num !== {4{32'd2}}) begin n_err++; $display("FAIL rr_counts: got %h want 2 per channel", write_num); end
      @(posedge clk); #1;
   endtask

   task automatic test_fill();
      logic [63:0] d; logic [1:0] r; int w; int acc = 0; bit got;
      do_reset();
      tvalid[0] = 1;
      for (int cyc = 0; cyc < 300 && acc < 257; cyc++) begin
         tdata[63:0] = 64'(acc);
         @(negedge clk); got = tready[0];
         @(posedge clk); #1;
         if (got) acc++;
      end
`ifdef AXIL_REGFILE_MC_WRAP_EN
      tvalid[0] = 0;
      n_vec++;
      if (acc !== 257) begin n_err++; $display("FAIL wrap_accepted: got %0d want 257", acc); end
      axil_read(32'd0, d, r);
      n_vec++;
      if (d !== 64'd256) begin n_err++; $display("FAIL wrap_word0: got %0d want 256", d); end
      axil_read(CSR_BASE, d, r);
      n_vec++;
      if (d !== 64'd257) begin n_err++; $display("FAIL wrap_csr0: got %0d want 257", d); end
      axil_read(32'd8, d, r);
      n_vec++;
      if (d !== 64'd1) begin n_err++; $display("FAIL wrap_word1: got %0d want 1", d); end
`else
      @(negedge clk);
      n_vec++;
      if (tready[0] !== 1'b0) begin n_err++; $display("FAIL full_tready: got %b want 0", tready[0]); end
      @(posedge clk); #1;
      tvalid[0] = 0;
      n_vec++;
      if (acc !== 256) begin n_err++; $display("FAIL full_accepted: got %0d want 256", acc); end
      n_vec++;
      if (write_num[31:0] !== 32'd256) begin n_err++; $display("FAIL full_write_num: got %0d want 256", write_num[31:0]); end
      axil_read(32'd255 * 8, d, r);
      n_vec++;
      if (d !== 64'd255) begin n_err++; $display("FAIL full_word255: got %0d want 255", d); end
      axil_write(CSR_BASE, 64'd0, r);
      n_vec++;
      if (r !== 2'b00) begin n_err++; $display("FAIL clr_bresp: got %b want 00", r); end
      send_beat(0, 64'h1234, 1'b0, w);
      n_vec++;
      if (w !== 0) begin n_err++; $display("FAIL post_clr_ready: waited %0d cycles want 0", w); end
      axil_read(32'd0, d, r);
      n_vec++;
      if (d !== 64'h1234) begin n_err++; $display("FAIL post_clr_word0: got %h want 1234", d); end
      axil_read(CSR_BASE, d, r);
      n_vec++;
      if (d !== 64'd1) begin n_err++; $display("FAIL post_clr_csr0: got %0d want 1", d); end
`endif
   endtask

   task automatic test_errors();
      logic [63:0] d; logic [1:0] r;
      axil_write(32'd40, 64'hDEAD, r);
      n_vec++;
      if (r !== 2'b10) begin n_err++; $display("FAIL data_wr_bresp: got %b want 10", r); end
      axil_read(32'd40, d, r);
      n_vec++;
      if (d !== 64'd5 || r !== 2'b00) begin n_err++; $display("FAIL data_word5: got %h/%b want 5/00", d, r); end
      axil_read(CSR_BASE + 32'd64, d, r);
      n_vec++;
      if (d !== 64'd0 || r !== 2'b10) begin n_err++; $display("FAIL csr8_read: got %h/%b want 0/10", d, r); end
      axil_read(CSR_BASE + 32'd8, d, r);
      n_vec++;
      if (d !== 64'd0 || r !== 2'b00) begin n_err++; $display("FAIL ch0_frames: got %0d/%b want 0/00", d, r); end
   endtask

   task automatic test_back_to_back_clear();
      logic [63:0] d; logic [1:0] r; int w;
      do_reset();
      send_beat(0, 64'h55, 1'b1, w);
      tdata[63:0] = 64'h66; tlast[0] = 0; tvalid[0] = 1;
      bus.awaddr = CSR_BASE + 32'd8; bus.wdata = '0; bus.wstrb = 8'h01;
      bus.awvalid = 1; bus.wvalid = 1; bus.bready = 1;
      @(negedge clk);
      n_vec++;
      if (bus.awready !== 1'b1 || tready[0] !== 1'b0) begin
         n_err++; $display("FAIL clr_collide: got awready=%b tready0=%b want 1/0", bus.awready, tready[0]);
      end
      @(posedge clk); #1;
      bus.awvalid = 0; bus.wvalid = 0;
      @(negedge clk);
      n_vec++;
      if (write_num[31:0] !== 32'd0 || tready[0] !== 1'b1) begin
         n_err++; $display("FAIL clr_after: got count=%0d tready0=%b want 0/1", write_num[31:0], tready[0]);
      end
      n_vec++;
      if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00) begin
         n_err++; $display("FAIL clr_b: got bvalid=%b bresp=%b want 1/00", bus.bvalid, bus.bresp);
      end
      @(posedge clk); #1;
      tvalid[0] = 0;
      axil_read(CSR_BASE, d, r);
      n_vec++;
      if (d !== 64'd1) begin n_err++; $display("FAIL clr_beats: got %0d want 1", d); end
      axil_read(CSR_BASE + 32'd8, d, r);
      n_vec++;
      if (d !== 64'd0) begin n_err++; $display("FAIL clr_frames: got %0d want 0", d); end
      axil_read(32'd0, d, r);
      n_vec++;
      if (d !== 64'h66) begin n_err++; $display("FAIL clr_word0: got %h want 66", d); end
   endtask

   initial begin
      test_reset();
      test_ch1_frame();
      test_round_robin();
      test_fill();
      test_errors();
      test_back_to_back_clear();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/axil_regfile_axis_mc_wr.md
AXIL_REGFILE_AXIS_MC_WR -- requirements
Module: axil_regfile_axis_mc_wr

Interface
REQ-001 Parameter: DATA_WIDTH, default 64, width of the AXI-Lite data bus and of each stream beat.
REQ-002 Parameter: ADDR_WIDTH, default 32, AXI-Lite byte-address width.
REQ-003 Parameter: STRB_WIDTH, default DATA_WIDTH/8, AXI-Lite write-strobe width.
REQ-004 Parameter: CH_NUM, default 4, number of stream channels (power of 2, 1..16).
REQ-005 Parameter: DEPTH, default 256, entries per channel bank (power of 2).
REQ-006 Ports, clock and reset first (single clock; reset asynchronous, active-high):
- axil_clk  in  1  sole clock
- axil_rst  in  1  async active-high reset
- s_axis_tdata  in  CH_NUM*DATA_WIDTH  channel c at slice c
- s_axis_tvalid / s_axis_tlast  in  CH_NUM  per channel
- s_axis_tready  out  CH_NUM  per channel
- axis_write_num  out  CH_NUM*32  per-channel beat count
- s_axil_aw*, w*, b*, ar*, r*  standard AXI-Lite slave, widths from ADDR_WIDTH, DATA_WIDTH, STRB_WIDTH; prot ignored

Function
REQ-007 Word index = byte address >> log2(STRB_WIDTH); B = log2(CH_NUM*DEPTH); word bit B = 0 selects data space, 1 selects CSR space; higher word bits are ignored.
REQ-008 Data space: entry i of channel c at word c*DEPTH+i; read-only over AXI-Lite; writes return SLVERR with no side effect.
REQ-009 CSR space: word 2c = beat count of channel c, word 2c+1 = frame (tlast) count, both zero-extended 32-bit; CSR words >= 2*CH_NUM read 0 with SLVERR.
REQ-010 Any AXI-Lite write to CSR word 2c or 2c+1 (any wstrb) clears beat count, frame count and write pointer of channel c; BRESP OKAY.
REQ-011 One bank write per cycle; a round-robin arbiter grants among valid, non-full channels; s_axis_tready[c] = grant[c] only.
REQ-012 Beat accepted on tvalid&tready; data written to entry ptr[c] on that edge and is visible to an AXI-Lite read issued on the next cycle; ptr[c] increments modulo DEPTH.
REQ-013 Accepted beat increments beat count; accepted beat with tlast also increments frame count; both counts saturate at 2^32-1.
REQ-014 Round-robin: after granting c, priority starts at c+1 mod CH_NUM; an idle channel takes no slot.
REQ-015 Clear and beat on the same channel in the same cycle: clear wins; tready[c] is held low that cycle.
REQ-016 AXI-Lite write: AW and W accepted together only when both valid and bvalid low; bvalid asserts next cycle and holds until bready.
REQ-017 AXI-Lite read: arready high when rvalid low; rdata/rresp registered, rvalid one cycle after AR handshake, held until rready.
REQ-018 axis_write_num slice c equals beat count of channel c, updated the cycle after acceptance.

Reset
REQ-019 axil_rst asserted: s_axis_tready, awready, wready, arready, bvalid, rvalid = 0; counts, pointers and arbiter priority = 0; bank contents undefined.
REQ-020 Reset mid-transaction abandons outstanding B/R responses; first post-reset grant goes to channel 0.

Configuration
REQ-021 Macro AXIL_REGFILE_MC_WRAP_EN defined: pointer wraps, oldest entries overwritten, channel never full.
REQ-022 Macro undefined: channel c full when beat count = DEPTH; tready[c] held 0 until cleared via REQ-010.

Structure
REQ-023 Shared package axil_regfile_pkg holds AXI response codes (OKAY, SLVERR) and CSR offset constants.
REQ-024 Sub-module axis_rr_arbiter (CH_NUM requests, one-hot grant, advance on accept).

Verification
REQ-025 CH_NUM=4, ch1 sends beats 0xA0..0xA3, last on 0xA3 -> data words 256..259 read 0xA0..0xA3; CSR 2 = 4, CSR 3 = 1.
REQ-026 All 4 channels valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3; each count = 2.
REQ-027 Without WRAP_EN, ch0 sends 257 beats -> 256 accepted, tready[0] low; write CSR 0 -> tready[0] high, next beat lands at word 0.
REQ-028 With WRAP_EN, ch0 sends 257 beats -> word 0 holds beat 256, CSR 0 = 257.
REQ-029 AXI-Lite write to data word 5 -> BRESP SLVERR, word unchanged; read CSR word 8 -> 0, RRESP SLVERR.
REQ-030 Clear CSR 0 in same cycle as ch0 valid -> tready[0] = 0 that cycle; counts read 0 afterwards, beat accepted next cycle.
